alu_share_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU among NUM_REQ requesters using round-robin arbitration and valid/ready handshakes.
- The ALU has operands A and B, a 3-bit ALUop, and outputs Result, Overflow, CarryOut and Zero.
- Each accepted request drives the ALU for one cycle, registers the result and flags, and holds them for the granted requester until it accepts them.
- Sits between the requester-side logic and a single ALU instance.

---
 rtl/alu_share_arbiter.sv | 105 ++++++++++
 tb/tb_alu_share_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU among NUM_REQ requesters; accept -> resp_valid two edges later, 3 cycles min per op.
// Backpressure: result is held in RESP until resp_ready of the granted requester; no new request is accepted meanwhile.
module alu_share_arbiter #(
    parameter int  DATA_WIDTH = 32,
    parameter int  ID_WIDTH   = 2,
    localparam int NUM_REQ    = 2**ID_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_A,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_B,
    input  logic [NUM_REQ*3-1:0]          req_op,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_Result,
    output logic                          resp_Overflow,
    output logic                          resp_CarryOut,
    output logic                          resp_Zero,
    output logic [DATA_WIDTH-1:0]         alu_A,
    output logic [DATA_WIDTH-1:0]         alu_B,
    output logic [2:0]                    alu_op,
    input  logic [DATA_WIDTH-1:0]         alu_Result,
    input  logic                          alu_Overflow,
    input  logic                          alu_CarryOut,
    input  logic                          alu_Zero,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [31:0]                   op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] win_idx;
    logic                win_found;

    // Scan from the highest offset down so the last hit is the one closest to rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_ptr + ID_WIDTH'(k)]) begin
                win_found = 1'b1;
                win_idx   = rr_ptr + ID_WIDTH'(k);
            end
        end
    end

    assign req_ready = (state == IDLE && win_found && !rst) ? (NUM_REQ'(1) << win_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_id      <= '0;
            op_count      <= '0;
            alu_A         <= '0;
            alu_B         <= '0;
            alu_op        <= '0;
            resp_Result   <= '0;
            resp_Overflow <= 1'b0;
            resp_CarryOut <= 1'b0;
            resp_Zero     <= 1'b0;
            resp_valid    <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        alu_A    <= req_A[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        alu_B    <= req_B[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        alu_op   <= req_op[win_idx*3 +: 3];
                        grant_id <= win_idx;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    resp_Result   <= alu_Result;
                    resp_Overflow <= alu_Overflow;
                    resp_CarryOut <= alu_CarryOut;
                    resp_Zero     <= alu_Zero;
                    resp_valid    <= NUM_REQ'(1) << grant_id;
                    state         <= RESP;
                end
                RESP: begin
                    if (resp_ready[grant_id]) begin
                        resp_valid <= '0;
                        op_count   <= op_count + 32'd1;
                        rr_ptr     <= grant_id + ID_WIDTH'(1);
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_alu_share_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [127:0] req_A, req_B;
    logic [11:0]  req_op;
    logic [31:0]  resp_Result, alu_A, alu_B, alu_Result, op_count;
    logic         resp_Overflow, resp_CarryOut, resp_Zero;
    logic         alu_Overflow, alu_CarryOut, alu_Zero, busy;
    logic [2:0]   alu_op;
    logic [1:0]   grant_id;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(32), .ID_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_Result(resp_Result), .resp_Overflow(resp_Overflow),
        .resp_CarryOut(resp_CarryOut), .resp_Zero(resp_Zero),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
        .alu_Result(alu_Result), .alu_Overflow(alu_Overflow),
        .alu_CarryOut(alu_CarryOut), .alu_Zero(alu_Zero),
        .busy(busy), .grant_id(grant_id), .op_count(op_count)
    );

    // Reference ALU: {Overflow, CarryOut, Zero, Result}; reserved codes get a code-dependent result.
    function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        ov, co;
        s = '0; r = '0; ov = 1'b0; co = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b110: begin
                s = {1'b0, a} - {1'b0, b}; r = s[31:0]; co = ~s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b111:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = a ^ b ^ {29'd0, op};
        endcase
        return {ov, co, (r == 32'd0), r};
    endfunction

    always_comb {alu_Overflow, alu_CarryOut, alu_Zero, alu_Result} = alu_fn(alu_A, alu_B, alu_op);

    function automatic int onehot_idx(input logic [3:0] v);
        int idx = -1;
        int n   = 0;
        for (int i = 0; i < 4; i++) if (v[i] === 1'b1) begin idx = i; n++; end
        return (n == 1) ? idx : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_A[i*32 +: 32] = a;
        req_B[i*32 +: 32] = b;
        req_op[i*3 +: 3]  = op;
        req_valid[i]      = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; resp_ready = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; resp_ready = '0;
        for (int i = 0; i < 4; i++) set_req(i, $urandom, $urandom, 3'($urandom));
        tick(); tick();
        n_cmp++;
        if ({req_ready, resp_valid, busy, grant_id, op_count, alu_A, alu_B, alu_op,
             resp_Result, resp_Overflow, resp_CarryOut, resp_Zero} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got rdy=%h rv=%h busy=%b gid=%0d cnt=%0d aA=%h aB=%h op=%0d res=%h flags=%b%b%b required all zero",
                     req_ready, resp_valid, busy, grant_id, op_count, alu_A, alu_B, alu_op,
                     resp_Result, resp_Overflow, resp_CarryOut, resp_Zero);
        end
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 32'd5, 32'd3, 3'b010);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_accept got %b required 0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_cmp++;
        if ({busy, grant_id, alu_A, alu_B, alu_op, resp_valid, req_ready} !== {1'b1, 2'd0, 32'd5, 32'd3, 3'b010, 4'b0, 4'b0}) begin
            n_err++;
            $display("FAIL single_exec got busy=%b gid=%0d A=%h B=%h op=%0d rv=%b rdy=%b", busy, grant_id, alu_A, alu_B, alu_op, resp_valid, req_ready);
        end
        tick();
        n_cmp++;
        if ({resp_valid, resp_Result, resp_Zero, resp_Overflow} !== {4'b0001, 32'd8, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL single_resp got rv=%b res=%0d z=%b ov=%b required 0001 8 0 0", resp_valid, resp_Result, resp_Zero, resp_Overflow);
        end
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        n_cmp++;
        if ({op_count, busy, resp_valid} !== {32'd1, 1'b0, 4'b0}) begin
            n_err++;
            $display("FAIL single_done got cnt=%0d busy=%b rv=%b required 1 0 0000", op_count, busy, resp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [34:0] pexp [4];
        logic [34:0] cur;
        int          gseq [$];
        int          acyc [$];
        int          w, want;
        logic [31:0] a, b;
        logic [2:0]  op;
        do_reset();
        resp_ready = 4'hF;
        cur = '0;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom; op = 3'($urandom);
            set_req(i, a, b, op); pexp[i] = alu_fn(a, b, op);
        end
        for (int c = 0; c < 18; c++) begin
            #1;
            w = onehot_idx(req_ready);
            if (w >= 0) begin gseq.push_back(w); acyc.push_back(c); cur = pexp[w]; end
            if (resp_valid !== 4'b0) begin
                n_cmp++;
                if ({resp_Overflow, resp_CarryOut, resp_Zero, resp_Result} !== cur) begin
                    n_err++;
                    $display("FAIL rr_result got %h required %h", {resp_Overflow, resp_CarryOut, resp_Zero, resp_Result}, cur);
                end
            end
            tick();
            if (w >= 0) begin
                a = $urandom; b = $urandom; op = 3'($urandom);
                set_req(w, a, b, op); pexp[w] = alu_fn(a, b, op);
            end
        end
        for (int k = 0; k < 6; k++) begin
            want = k % 4;
            n_cmp++;
            if ((k < gseq.size() ? gseq[k] : -1) !== want || (k < acyc.size() ? acyc[k] : -1) !== 3 * k) begin
                n_err++;
                $display("FAIL rr_grant%0d got id=%0d cyc=%0d required id=%0d cyc=%0d", k,
                         k < gseq.size() ? gseq[k] : -1, k < acyc.size() ? acyc[k] : -1, want, 3 * k);
            end
        end
        n_cmp++;
        if (op_count !== 32'd6 || gseq.size() != 6) begin
            n_err++;
            $display("FAIL rr_count got cnt=%0d grants=%0d required 6 6", op_count, gseq.size());
        end
        req_valid = '0;
    endtask

    task automatic test_fairness();
        int gseq [$];
        int w;
        do_reset();
        resp_ready = 4'hF;
        set_req(0, $urandom, $urandom, 3'b010);
        for (int c = 0; c < 12; c++) begin
            if (c == 2) set_req(2, $urandom, $urandom, 3'b110);
            #1;
            w = onehot_idx(req_ready);
            if (w >= 0) gseq.push_back(w);
            tick();
            if (w == 2) req_valid[2] = 1'b0;
        end
        n_cmp++;
        if (gseq.size() < 3 || gseq[0] != 0 || gseq[1] != 2 || gseq[2] != 0) begin
            n_err++;
            $display("FAIL fair_order got %p required 0,2,0 first", gseq);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b010);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_accept got %b required 0010", req_ready); end
        tick();
        req_valid = '0;
        set_req(0, 32'd10, 32'd20, 3'b001);
        set_req(3, 32'd7, 32'd9, 3'b000);
        tick();
        resp_ready = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if ({resp_valid, resp_Result, resp_CarryOut, resp_Zero, resp_Overflow, req_ready, busy}
                !== {4'b0010, 32'd0, 1'b1, 1'b1, 1'b0, 4'b0, 1'b1}) begin
                n_err++;
                $display("FAIL bp_hold%0d got rv=%b res=%h co=%b z=%b ov=%b rdy=%b busy=%b", c,
                         resp_valid, resp_Result, resp_CarryOut, resp_Zero, resp_Overflow, req_ready, busy);
            end
            tick();
        end
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        #1;
        n_cmp++;
        if ({req_ready, op_count} !== {4'b1000, 32'd1}) begin
            n_err++;
            $display("FAIL bp_release got rdy=%b cnt=%0d required 1000 1", req_ready, op_count);
        end
        req_valid = '0;
    endtask

    task automatic test_flags();
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic [2:0]  top [5];
        logic [34:0] e;
        ta[0] = 32'h7FFF_FFFF; tb[0] = 32'd1;      top[0] = 3'b010;
        ta[1] = 32'h1234;      tb[1] = 32'h1234;   top[1] = 3'b110;
        for (int k = 2; k < 5; k++) begin ta[k] = $urandom; tb[k] = $urandom; top[k] = 3'(k + 1); end
        do_reset();
        resp_ready = 4'hF;
        for (int k = 0; k < 5; k++) begin
            e = alu_fn(ta[k], tb[k], top[k]);
            if (k == 0) e = {1'b1, 1'b0, 1'b0, 32'h8000_0000};
            if (k == 1) e = {1'b0, 1'b1, 1'b1, 32'h0};
            set_req(2, ta[k], tb[k], top[k]);
            #1;
            n_cmp++;
            if (req_ready !== 4'b0100) begin n_err++; $display("FAIL flags_accept%0d got %b required 0100", k, req_ready); end
            tick();
            req_valid = '0;
            n_cmp++;
            if ({alu_A, alu_B, alu_op} !== {ta[k], tb[k], top[k]}) begin
                n_err++;
                $display("FAIL flags_drive%0d got A=%h B=%h op=%0d required A=%h B=%h op=%0d", k, alu_A, alu_B, alu_op, ta[k], tb[k], top[k]);
            end
            tick();
            n_cmp++;
            if ({resp_valid, resp_Overflow, resp_CarryOut, resp_Zero, resp_Result} !== {4'b0100, e}) begin
                n_err++;
                $display("FAIL flags_resp%0d got rv=%b %h required 0100 %h", k, resp_valid,
                         {resp_Overflow, resp_CarryOut, resp_Zero, resp_Result}, e);
            end
            tick();
        end
    endtask

    task automatic test_reset_exec();
        do_reset();
        resp_ready = 4'hF;
        set_req(1, 32'd1, 32'd2, 3'b010);
        tick();
        req_valid = '0;
        tick(); tick();
        set_req(3, 32'd4, 32'd4, 3'b110);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({req_ready, resp_valid, busy, grant_id, op_count, alu_A, alu_B, alu_op,
             resp_Result, resp_Overflow, resp_CarryOut, resp_Zero} !== '0) begin
            n_err++;
            $display("FAIL rstexec_outputs got rv=%b busy=%b gid=%0d cnt=%0d A=%h B=%h op=%0d res=%h required all zero",
                     resp_valid, busy, grant_id, op_count, alu_A, alu_B, alu_op, resp_Result);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({resp_valid, op_count, busy} !== '0) begin
                n_err++;
                $display("FAIL rstexec_quiet%0d got rv=%b cnt=%0d busy=%b required 0 0 0", c, resp_valid, op_count, busy);
            end
        end
        set_req(1, 32'd1, 32'd1, 3'b000);
        set_req(3, 32'd3, 32'd3, 3'b000);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rstexec_ptr got %b required 0010", req_ready); end
        req_valid = '0;
        resp_ready = '0;
    endtask

    // Transaction-level model: pending requests, one outstanding op, pointer moves past the last completed grant.
    task automatic test_random();
        bit          pend [4];
        logic [34:0] pexp [4];
        logic [34:0] oexp;
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [3:0]  exp_rdy, exp_rv;
        bit          outst, hs;
        int          g, age, mptr, cnt, ew;
        do_reset();
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        oexp = '0; outst = 1'b0; g = 0; age = 0; mptr = 0; cnt = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    a = $urandom; b = $urandom; op = 3'($urandom);
                    if ($urandom_range(0, 7) == 0) b = a;
                    set_req(i, a, b, op); pend[i] = 1'b1; pexp[i] = alu_fn(a, b, op);
                end
            end
            resp_ready = 4'($urandom_range(0, 15));
            #1;
            ew = -1;
            if (!outst) for (int k = 0; k < 4; k++) if (ew < 0 && pend[(mptr + k) % 4]) ew = (mptr + k) % 4;
            exp_rdy = (ew >= 0) ? 4'(1 << ew) : 4'b0;
            exp_rv  = (outst && age >= 2) ? 4'(1 << g) : 4'b0;
            n_cmp++;
            if ({req_ready, resp_valid, busy, op_count} !== {exp_rdy, exp_rv, outst, 32'(cnt)}) begin
                n_err++;
                $display("FAIL rand_ctl c=%0d got rdy=%b rv=%b busy=%b cnt=%0d required rdy=%b rv=%b busy=%b cnt=%0d",
                         c, req_ready, resp_valid, busy, op_count, exp_rdy, exp_rv, outst, cnt);
            end
            if (exp_rv != 4'b0) begin
                n_cmp++;
                if ({resp_Overflow, resp_CarryOut, resp_Zero, resp_Result} !== oexp) begin
                    n_err++;
                    $display("FAIL rand_data c=%0d got %h required %h", c, {resp_Overflow, resp_CarryOut, resp_Zero, resp_Result}, oexp);
                end
            end
            hs = (exp_rv != 4'b0) && resp_ready[g];
            tick();
            age++;
            if (hs) begin outst = 1'b0; mptr = (g + 1) % 4; cnt++; end
            if (ew >= 0) begin
                outst = 1'b1; g = ew; age = 1; oexp = pexp[ew];
                pend[ew] = 1'b0; req_valid[ew] = 1'b0;
            end
        end
        req_valid = '0;
        resp_ready = '0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; resp_ready = '0;
        req_A = '0; req_B = '0; req_op = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_backpressure();
        test_flags();
        test_reset_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
